lfsr_launcher: RTL and testbench
================================

# lfsr_launcher

Parametrised random-number launcher: a WIDTH-bit Fibonacci LFSR with programmable taps, seed loading, zero-lock recovery and four advance modes (free-run, single-step, counted burst, hold). It sits between the board buttons/switches and the display path, generalising the fixed 8-bit free-running generator. Optionally it drives two hex seven-segment digits directly.

## Interface
- WIDTH, 8: LFSR width, 4..32.
- TAPS, 8'h1D: feedback mask, bit i set means num[i] enters the XOR.
- SEED, 1: reset and default seed value; 0 is replaced by 1.
- BURST_W, 8: width of the burst length counter.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_mode  in  2  0 free-run, 1 step, 2 burst, 3 hold.
- i_btn  in  1  launch button, already synchronised and debounced, level.
- i_seed_load  in  1  load i_seed this cycle.
- i_seed  in  WIDTH  seed value.
- i_burst_len  in  BURST_W  number of advances per burst.
- o_num  out  WIDTH  current LFSR state, registered.
- o_valid  out  1  high in every cycle in which o_num shows a newly advanced value.
- o_busy  out  1  burst in progress.
- o_done  out  1  one-cycle pulse when a burst finishes.

## Operation
- Advance: num <= {num[WIDTH-2:0], fb}, fb = ^(num & TAPS). If num == 0, fb is forced to 1, so a zero state always recovers to 1.
- Launch edge: btn_q holds i_btn from the previous cycle. edge = i_btn & ~btn_q.
- Priority per cycle: rst > i_seed_load > advance.
- Seed load: num <= (i_seed == 0) ? 1 : i_seed. There is no o_valid for a seed load. A seed load during a burst aborts it: FSM goes to IDLE with no o_done.
- Mode 0: advance every cycle while FSM is IDLE.
- Mode 1: advance once per launch edge.
- Mode 3: no advance. Edges are ignored.
- Mode 2 FSM with states IDLE, RUN, DONE:
  - IDLE, edge, i_burst_len == 0: go to DONE with no advance.
  - IDLE, edge, i_burst_len == N > 0: cnt <= N, go to RUN.
  - RUN: advance each cycle and decrement cnt. On the advance made with cnt == 1, go to DONE.
  - DONE: o_done = 1 for one cycle, then IDLE.
  - The mode is sampled only at launch. Changing i_mode during RUN/DONE does not affect the burst. Edges during RUN/DONE are ignored.
- o_busy = (state == RUN).

## Timing
- Reset values:
  - o_num = SEED, or 1 if SEED == 0.
  - o_valid = 0, o_busy = 0, o_done = 0.
  - state = IDLE, cnt = 0.
  - btn_q = 1, so a button held through reset does not launch.
- Step mode: edge in cycle t gives the new o_num and o_valid = 1 in cycle t+1.
- Burst of N: edge in cycle t gives o_busy = 1 in t+1..t+N. o_valid = 1 and a new o_num appear in t+2..t+N+1. o_done = 1 in t+N+1 (with the last value). FSM is back in IDLE at t+N+2.
- Burst with N = 0: o_done = 1 in t+1, o_valid stays 0.
- Free-run: o_valid = 1 every cycle from the second cycle after reset release.
- Reset mid-burst: the next cycle shows all reset values. There is no o_done.

## Configuration
- LFSR_LAUNCHER_SEG_EN defined:
  - Adds outputs o_seg0 and o_seg1 (each 8 bits): hex digits of o_num[3:0] and o_num[7:4].
  - Decoded combinationally from the registered o_num.
  - Bit order {dp,g,f,e,d,c,b,a}, active-low, dp always 1.
  - For WIDTH < 8, the missing upper bits read as 0.
- Undefined: the ports and decode logic are absent.

## Test plan
- Reset, WIDTH=8, TAPS=8'h1D, SEED=1, mode 1, three button presses -> o_num 0x01 -> 0x03 -> 0x07 -> 0x0E, one o_valid per press.
- Seed load 0x00 -> o_num = 0x01, no o_valid. Seed load 0xA5, one step -> o_num = 0x4A.
- Mode 2, i_burst_len = 3 from 0x01 -> o_busy = 1 for 3 cycles, o_num 0x03/0x07/0x0E, o_done = 1 coincident with 0x0E, then IDLE. Burst with len 0 -> o_done = 1 next cycle, o_num unchanged.
- Burst len 10 with i_seed_load in its 4th RUN cycle -> new seed appears, o_busy drops, o_done never asserts.
- i_btn high through reset release, mode 1 -> no advance until the button is released and pressed again. Mode 3 with repeated presses -> o_num constant.
- With LFSR_LAUNCHER_SEG_EN, o_num = 0x3C -> o_seg0 = 8'hC6 ('C'), o_seg1 = 8'hB0 ('3').

Source files
------------

// File: rtl/lfsr_launcher.sv
// Fibonacci LFSR launcher: free-run / step / counted burst / hold, with seed load and zero-lock recovery.
// Define LFSR_LAUNCHER_SEG_EN to add two active-low hex seven-segment outputs.
module lfsr_launcher #(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0]  TAPS    = 'h1D,
   parameter logic [WIDTH-1:0]  SEED    = 'd1,
   parameter int unsigned       BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         i_mode,
   input  logic               i_btn,
   input  logic               i_seed_load,
   input  logic [WIDTH-1:0]   i_seed,
   input  logic [BURST_W-1:0] i_burst_len,
   output logic [WIDTH-1:0]   o_num,
   output logic               o_valid,
   output logic               o_busy,
   output logic               o_done
`ifdef LFSR_LAUNCHER_SEG_EN
   ,
   output logic [7:0]         o_seg0,
   output logic [7:0]         o_seg1
`endif
);

   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [1:0] MODE_FREE  = 2'd0;
   localparam logic [1:0] MODE_STEP  = 2'd1;
   localparam logic [1:0] MODE_BURST = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [BURST_W-1:0]   cnt;
   logic                 btn_q;
   logic                 btn_edge;
   logic                 advance;
   logic                 fb;
   logic [WIDTH-1:0]     num_next;
   logic [WIDTH-1:0]     seed_eff;

   // Launch edge and LFSR next value; an all-zero state is forced back to 1.
   always_comb begin
      btn_edge = i_btn & ~btn_q;
      fb       = (o_num == '0) ? 1'b1 : ^(o_num & TAPS);
      num_next = {o_num[WIDTH-2:0], fb};
      seed_eff = (i_seed == '0) ? WIDTH'(1) : i_seed;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state: a seed load always returns to IDLE and suppresses a launch
   always_comb begin
      next_state = state;
      if (i_seed_load) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (i_mode == MODE_BURST && btn_edge)
                  next_state = (i_burst_len == '0) ? DONE : RUN;
            end
            RUN: begin
               if (cnt == BURST_W'(1)) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Outputs decoded from the state register, plus the advance strobe
   always_comb begin
      o_busy  = (state == RUN);
      o_done  = (state == DONE);
      advance = 1'b0;
      if (!i_seed_load) begin
         case (state)
            IDLE:    advance = (i_mode == MODE_FREE) || (i_mode == MODE_STEP && btn_edge);
            RUN:     advance = 1'b1;
            default: advance = 1'b0;
         endcase
      end
   end

   // LFSR, valid flag, burst counter and button history
   always_ff @(posedge clk) begin
      if (rst) begin
         o_num   <= SEED_EFF;
         o_valid <= 1'b0;
         cnt     <= '0;
         btn_q   <= 1'b1;
      end else begin
         btn_q   <= i_btn;
         o_valid <= advance;
         if (i_seed_load)   o_num <= seed_eff;
         else if (advance)  o_num <= num_next;
         if (state == IDLE && next_state == RUN)
            cnt <= i_burst_len;
         else if (state == RUN && advance)
            cnt <= cnt - BURST_W'(1);
      end
   end

`ifdef LFSR_LAUNCHER_SEG_EN
   logic [7:0] seg_src;

   // Active-low {dp,g,f,e,d,c,b,a}, dp held off
   function automatic logic [7:0] hex_seg(input logic [3:0] d);
      logic [6:0] on;
      case (d)
         4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
         4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
         4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
         4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
      endcase
      return {1'b1, ~on};
   endfunction

   always_comb begin
      seg_src = 8'(o_num);
      o_seg0  = hex_seg(seg_src[3:0]);
      o_seg1  = hex_seg(seg_src[7:4]);
   end
`else
   // Seven-segment outputs and decode are not built
`endif

endmodule

// File: tb/tb_lfsr_launcher.sv
// Bench for lfsr_launcher: cycle-level reference model checked every cycle, directed scenarios, random phase.
// Seven-segment checks are included when LFSR_LAUNCHER_SEG_EN is defined.
module tb_lfsr_launcher;

   localparam logic [7:0] TAPS_B = 8'h1D;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       btn;
   logic       seed_load;
   logic [7:0] seed;
   logic [7:0] burst_len;
   logic [7:0] num;
   logic       valid;
   logic       busy;
   logic       done;
`ifdef LFSR_LAUNCHER_SEG_EN
   logic [7:0] seg0;
   logic [7:0] seg1;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   lfsr_launcher dut (
      .clk         (clk),
      .rst         (rst),
      .i_mode      (mode),
      .i_btn       (btn),
      .i_seed_load (seed_load),
      .i_seed      (seed),
      .i_burst_len (burst_len),
      .o_num       (num),
      .o_valid     (valid),
      .o_busy      (busy),
      .o_done      (done)
`ifdef LFSR_LAUNCHER_SEG_EN
      ,
      .o_seg0      (seg0),
      .o_seg1      (seg1)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One LFSR advance from the rule: shift left, feed back parity of tapped bits, zero goes to 1
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      int ones = 0;
      if (v == 8'h00) return 8'h01;
      for (int i = 0; i < 8; i++) if (TAPS_B[i] && v[i]) ones++;
      return {v[6:0], 1'(ones % 2)};
   endfunction

   // Reference model: remaining burst advances and a pending-done flag describe the burst
   logic [7:0] m_num;
   logic       m_valid;
   logic       m_done;
   int         m_rem;
   logic       m_prev;

   always @(posedge clk) begin : model
      bit e;
      bit was_done;
      if (rst) begin
         m_num = 8'h01; m_valid = 1'b0; m_done = 1'b0; m_rem = 0; m_prev = 1'b1;
      end else begin
         e        = btn && !m_prev;
         m_prev   = btn;
         was_done = m_done;
         m_valid  = 1'b0;
         m_done   = 1'b0;
         if (seed_load) begin
            m_num = (seed == 8'h00) ? 8'h01 : seed;
            m_rem = 0;
         end else if (m_rem > 0) begin
            m_num   = lfsr_next(m_num);
            m_valid = 1'b1;
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
         end else if (!was_done) begin
            case (mode)
               2'd0: begin m_num = lfsr_next(m_num); m_valid = 1'b1; end
               2'd1: if (e) begin m_num = lfsr_next(m_num); m_valid = 1'b1; end
               2'd2: if (e) begin
                  if (burst_len == 8'd0) m_done = 1'b1;
                  else m_rem = int'(burst_len);
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LFSR_LAUNCHER_SEG_EN
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`endif

   // Compare DUT to model every cycle, away from the active edge
   always @(negedge clk) begin
      if (check_en) begin
         chk8("model_num", num, m_num);
         chk1("model_valid", valid, m_valid);
         chk1("model_busy", busy, (m_rem > 0));
         chk1("model_done", done, m_done);
`ifdef LFSR_LAUNCHER_SEG_EN
         chk8("model_seg0", seg0, {1'b1, ~seg_tab[m_num[3:0]]});
         chk8("model_seg1", seg1, {1'b1, ~seg_tab[m_num[7:4]]});
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press: button high for one cycle; returns in the cycle after the edge
   task automatic press();
      btn = 1'b1;
      tick(1);
   endtask

   task automatic release_btn();
      btn = 1'b0;
      tick(1);
   endtask

   initial begin
      rst = 1'b1; mode = 2'd1; btn = 1'b0; seed_load = 1'b0; seed = 8'h00; burst_len = 8'd0;
      tick(1);
      check_en = 1'b1;
      tick(1);
      chk8("reset_num", num, 8'h01);
      chk1("reset_valid", valid, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);

      // Step mode: three presses
      rst = 1'b0;
      tick(1);
      chk8("step_idle", num, 8'h01);
      press();       chk8("step1", num, 8'h03); chk1("step1_valid", valid, 1'b1);
      release_btn(); chk1("step1_valid_drop", valid, 1'b0);
      press();       chk8("step2", num, 8'h07);
      release_btn();
      press();       chk8("step3", num, 8'h0E);
      release_btn();

      // Seed loads
      seed_load = 1'b1; seed = 8'h00; tick(1);
      chk8("seed_zero", num, 8'h01); chk1("seed_zero_valid", valid, 1'b0);
      seed = 8'hA5; tick(1);
      chk8("seed_a5", num, 8'hA5);
      seed_load = 1'b0;
      press(); chk8("seed_a5_step", num, 8'h4A);
      release_btn();

      // Burst of 3 from 0x01
      seed_load = 1'b1; seed = 8'h01; tick(1); seed_load = 1'b0;
      mode = 2'd2; burst_len = 8'd3;
      press();       chk1("b3_busy1", busy, 1'b1); chk8("b3_num0", num, 8'h01);
      release_btn(); chk8("b3_num1", num, 8'h03); chk1("b3_busy2", busy, 1'b1);
      tick(1);       chk8("b3_num2", num, 8'h07); chk1("b3_busy3", busy, 1'b1);
      tick(1);       chk8("b3_num3", num, 8'h0E); chk1("b3_done", done, 1'b1); chk1("b3_busy_off", busy, 1'b0);
      tick(1);       chk1("b3_done_pulse", done, 1'b0);

      // Burst of 0
      burst_len = 8'd0;
      press();       chk1("b0_done", done, 1'b1); chk8("b0_num", num, 8'h0E); chk1("b0_valid", valid, 1'b0);
      release_btn(); chk1("b0_done_off", done, 1'b0);

      // Burst of 10 aborted by a seed load in its 4th RUN cycle
      burst_len = 8'd10;
      press();                  // first RUN cycle
      release_btn(); tick(2);   // fourth RUN cycle
      chk1("abort_busy_before", busy, 1'b1);
      seed_load = 1'b1; seed = 8'h5C; tick(1); seed_load = 1'b0;
      chk8("abort_seed", num, 8'h5C); chk1("abort_busy", busy, 1'b0); chk1("abort_valid", valid, 1'b0);
      tick(12);

      // Button held through reset release
      rst = 1'b1; mode = 2'd1; btn = 1'b1; tick(2);
      rst = 1'b0; tick(3);
      chk8("held_btn", num, 8'h01);
      release_btn(); chk8("held_release", num, 8'h01);
      press(); chk8("held_repress", num, 8'h03);
      release_btn();

      // Hold mode ignores presses
      mode = 2'd3;
      for (int i = 0; i < 3; i++) begin
         press(); chk8("hold", num, 8'h03);
         release_btn();
      end

`ifdef LFSR_LAUNCHER_SEG_EN
      seed_load = 1'b1; seed = 8'h3C; tick(1); seed_load = 1'b0;
      chk8("seg0_c", seg0, 8'hC6); chk8("seg1_3", seg1, 8'hB0);
`endif

      // Free-run from 0x01
      seed_load = 1'b1; seed = 8'h01; tick(1); seed_load = 1'b0;
      mode = 2'd0;
      tick(1); chk8("free1", num, 8'h03); chk1("free1_valid", valid, 1'b1);
      tick(1); chk8("free2", num, 8'h07);
      tick(1); chk8("free3", num, 8'h0E);
      tick(20);

      // Randomized phase against the model
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         seed_load = ($urandom_range(0, 39) == 0);
         seed      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 2) == 0) btn = ~btn;
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 7) == 0) burst_len = 8'($urandom_range(0, 6));
         tick(1);
      end
      rst = 1'b0; seed_load = 1'b0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
